// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared constants and FSM encoding for the instruction memory
//               loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Frame start marker
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : 8-to-32 big-endian shift register. Emits a one-cycle
//               word_ready pulse the cycle after the fourth byte is shifted in;
//               the word stays stable during that pulse as long as no new byte
//               is shifted.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] count;

    // Shift bytes in MSB first and flag completion of every fourth byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word       <= 32'd0;
            count      <= 2'd0;
            word_ready <= 1'b0;
        end else if (clear) begin
            word       <= 32'd0;
            count      <= 2'd0;
            word_ready <= 1'b0;
        end else if (shift_en) begin
            word       <= {word[23:0], byte_in};
            count      <= count + 2'd1;
            word_ready <= (count == 2'd3);
        end else begin
            word_ready <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a framed program image over a valid/ready byte
//               stream, writes big-endian words into instruction memory,
//               verifies an XOR checksum and holds the CPU in reset until a
//               load completes cleanly.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] LOAD_BASE = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_write_enabled,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err_checksum,
    output logic        err_length
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] index;
    logic [7:0]  checksum;
    logic [15:0] len_full;
    logic        accept;
    logic        restart;
    logic        shift_en;
    logic        len_too_big;
    logic [31:0] word;
    logic        word_ready;

    // The write strobe cycle is the only cycle in which bytes are refused,
    // so a strobe and an incoming byte can never collide.
    assign rx_ready          = ~mem_write_enabled;
    assign accept            = rx_valid & rx_ready;
    assign mem_write_enabled = word_ready;
    assign mem_data          = word;
    assign mem_address       = LOAD_BASE + {16'd0, index};
    assign len_full          = {len_hi, rx_data};
    assign len_too_big       = ({16'd0, len_full} > MAX_LEN);
    assign restart           = accept && (rx_data == SYNC_BYTE) &&
                               ((state == ST_SYNC) || (state == ST_DONE) ||
                                (state == ST_ERROR));
    assign shift_en          = accept && (state == ST_DATA);

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (restart),
        .shift_en   (shift_en),
        .byte_in    (rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus state-decoded status outputs
    always_comb begin
        state_next = state;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            ST_SYNC: begin
                if (restart) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_too_big)            state_next = ST_ERROR;
                    else if (len_full == 16'd0) state_next = ST_CHECK;
                    else                        state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // Leave once the strobe for the last word has gone out
                if (mem_write_enabled && ((index + 16'd1) == len)) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) state_next = (rx_data == checksum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (restart) state_next = ST_LEN_HI;
            end
            ST_ERROR: begin
                if (restart) state_next = ST_LEN_HI;
            end
            default: state_next = ST_SYNC;
        endcase
    end

    // Length capture, checksum accumulation, word index and error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_hi       <= 8'd0;
            len          <= 16'd0;
            index        <= 16'd0;
            checksum     <= 8'd0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
        end else begin
            if (restart) begin
                checksum     <= 8'd0;
                index        <= 16'd0;
                err_checksum <= 1'b0;
                err_length   <= 1'b0;
            end else if (accept) begin
                case (state)
                    ST_LEN_HI: begin
                        len_hi   <= rx_data;
                        checksum <= checksum ^ rx_data;
                    end
                    ST_LEN_LO: begin
                        len      <= len_full;
                        checksum <= checksum ^ rx_data;
                        if (len_too_big) err_length <= 1'b1;
                    end
                    ST_DATA: begin
                        checksum <= checksum ^ rx_data;
                    end
                    ST_CHECK: begin
                        if (rx_data != checksum) err_checksum <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // A strobe cycle never accepts a byte, so this cannot race restart
            if (mem_write_enabled) index <= index + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. A frame-level reference
//               model parses the same byte stream and predicts the memory
//               writes and final status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          MAX_W = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_write_enabled;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        err_checksum;
    logic        err_length;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        b2b;
    } wr_t;

    wr_t        obs[$];
    wr_t        exp_w[$];
    logic [7:0] stream[$];
    logic       prev_we = 1'b0;
    logic       exp_done, exp_errc, exp_errl;

    imem_loader #(.MAX_WORDS(MAX_W), .LOAD_BASE(BASE)) dut (
        .clock             (clock),
        .reset             (reset),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .mem_write_enabled (mem_write_enabled),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .cpu_hold          (cpu_hold),
        .done              (done),
        .err_checksum      (err_checksum),
        .err_length        (err_length)
    );

    always #5 clock = ~clock;

    // Record every write strobe, with rx_ready and back-to-back status
    always @(negedge clock) begin
        if (mem_write_enabled === 1'b1)
            obs.push_back('{mem_address, mem_data, rx_ready, prev_we});
        prev_we = mem_write_enabled;
    end

    // Frame-level reference: scan for sync, read length, words, checksum
    task automatic model();
        int i = 0;
        int n = stream.size();
        logic [15:0] ln;
        logic [7:0]  chk;
        exp_w.delete();
        exp_done = 0; exp_errc = 0; exp_errl = 0;
        while (i < n) begin
            if (stream[i] != 8'hA5) begin i++; continue; end
            i++;
            exp_done = 0; exp_errc = 0; exp_errl = 0;
            if (i + 2 > n) break;
            ln  = {stream[i], stream[i+1]};
            chk = stream[i] ^ stream[i+1];
            i += 2;
            if (int'(ln) > MAX_W) begin exp_errl = 1; continue; end
            for (int w = 0; w < int'(ln); w++) begin
                exp_w.push_back('{BASE + 32'(w),
                                  {stream[i], stream[i+1], stream[i+2], stream[i+3]}, 1'b0, 1'b0});
                chk = chk ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
                i += 4;
            end
            if (i >= n) break;
            if (stream[i] == chk) exp_done = 1; else exp_errc = 1;
            i++;
        end
    endtask

    function automatic void add_frame(input int ln, input bit corrupt);
        logic [7:0] c;
        logic [7:0] b;
        stream.push_back(8'hA5);
        stream.push_back(ln[15:8]);
        stream.push_back(ln[7:0]);
        if (ln > MAX_W) return;
        c = ln[15:8] ^ ln[7:0];
        for (int k = 0; k < 4 * ln; k++) begin
            b = 8'($urandom);
            stream.push_back(b);
            c = c ^ b;
        end
        stream.push_back(corrupt ? (c ^ 8'h5A) : c);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w = 0;
        if (gaps) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin @(negedge clock); rx_valid = 1'b0; end
        end
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && w < 20) begin @(negedge clock); w++; end
        if (w >= 20) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send_stream(input bit gaps);
        foreach (stream[k]) send_byte(stream[k], gaps);
        @(negedge clock);
        rx_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        obs.delete();
        stream.delete();
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, cpu_hold, done, err_checksum, err_length, mem_write_enabled} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 110000",
                     {rx_ready, cpu_hold, done, err_checksum, err_length, mem_write_enabled});
        end
        checks++;
        if (mem_address !== BASE || mem_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: got addr=%h data=%h required %h/0", mem_address, mem_data, BASE);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_normal_load();
        do_reset();
        stream = '{8'h13, 8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h00, 8'h00, 8'h00, 8'h13};
        foreach (stream[k]) send_byte(stream[k], 1'b0);
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL normal_pre_chk: cpu_hold=%b done=%b required 1/0", cpu_hold, done);
        end
        send_byte(8'h33, 1'b0);
        stream.push_back(8'h33);
        checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL normal_post_chk: cpu_hold=%b done=%b required 0/1", cpu_hold, done);
        end
        @(negedge clock); rx_valid = 1'b0;
        repeat (2) @(negedge clock);
        model();
        checks++;
        if (obs.size() != 2 || exp_w.size() != 2) begin
            errors++;
            $display("FAIL normal_write_count: got %0d required 2", obs.size());
        end else foreach (exp_w[k]) begin
            checks++;
            if (obs[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL normal_write%0d: got %h@%h rdy=%b b2b=%b required %h@%h rdy=0 b2b=0",
                         k, obs[k].data, obs[k].addr, obs[k].rdy, obs[k].b2b, exp_w[k].data, exp_w[k].addr);
            end
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h00, 8'h00, 8'h00, 8'h13, 8'h34};
        send_stream(1'b0);
        checks++;
        if ({err_checksum, cpu_hold, done, err_length} !== 4'b1100) begin
            errors++;
            $display("FAIL badchk_flags: got errc/hold/done/errl=%b required 1100",
                     {err_checksum, cpu_hold, done, err_length});
        end
        model();
        checks++;
        if (obs.size() != exp_w.size()) begin
            errors++;
            $display("FAIL badchk_write_count: got %0d required %0d", obs.size(), exp_w.size());
        end else foreach (exp_w[k]) begin
            checks++;
            if (obs[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL badchk_write%0d: got %h@%h required %h@%h",
                         k, obs[k].data, obs[k].addr, exp_w[k].data, exp_w[k].addr);
            end
        end
    endtask

    task automatic test_length_overflow();
        do_reset();
        stream = '{8'hA5, 8'h01, 8'h01};
        send_stream(1'b0);
        checks++;
        if ({err_length, cpu_hold, done} !== 3'b110 || obs.size() != 0) begin
            errors++;
            $display("FAIL overflow: errl/hold/done=%b writes=%0d required 110 and 0",
                     {err_length, cpu_hold, done}, obs.size());
        end
        stream = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_stream(1'b0);
        checks++;
        if ({done, err_length, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL overflow_recover: done/errl/hold=%b required 100",
                     {done, err_length, cpu_hold});
        end
    endtask

    task automatic test_zero_length();
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_stream(1'b1);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || obs.size() != 0) begin
            errors++;
            $display("FAIL zero_len: done=%b hold=%b writes=%0d required 1/0/0", done, cpu_hold, obs.size());
        end
        send_byte(8'hA5, 1'b0);
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_restart: hold=%b done=%b required 1/0", cpu_hold, done);
        end
        @(negedge clock); rx_valid = 1'b0;
    endtask

    task automatic test_handshake_gaps();
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h00, 8'h00, 8'h00, 8'h13, 8'h33};
        send_stream(1'b1);
        model();
        checks++;
        if (obs.size() != exp_w.size() || done !== exp_done) begin
            errors++;
            $display("FAIL gaps_count: writes=%0d done=%b required %0d/%b", obs.size(), done, exp_w.size(), exp_done);
        end else foreach (exp_w[k]) begin
            checks++;
            if (obs[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL gaps_write%0d: got %h@%h rdy=%b b2b=%b required %h@%h rdy=0 b2b=0",
                         k, obs[k].data, obs[k].addr, obs[k].rdy, obs[k].b2b, exp_w[k].data, exp_w[k].addr);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD};
        foreach (stream[k]) send_byte(stream[k], 1'b0);
        @(negedge clock);
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, cpu_hold, done, err_checksum, err_length, mem_write_enabled} !== 6'b110000 ||
            mem_address !== BASE || mem_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_async: flags=%b addr=%h data=%h required 110000/%h/0",
                     {rx_ready, cpu_hold, done, err_checksum, err_length, mem_write_enabled},
                     mem_address, mem_data, BASE);
        end
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("FAIL midreset_strobe: got %0d writes required 0", obs.size());
        end
        stream.delete();
        add_frame(3, 1'b0);
        send_stream(1'b0);
        model();
        checks++;
        if (obs.size() != exp_w.size() || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload: writes=%0d done=%b required %0d/1", obs.size(), done, exp_w.size());
        end else foreach (exp_w[k]) begin
            checks++;
            if (obs[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL midreset_write%0d: got %h@%h required %h@%h",
                         k, obs[k].data, obs[k].addr, exp_w[k].data, exp_w[k].addr);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 6; r++) begin
            int ln;
            bit bad;
            do_reset();
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                logic [7:0] junk = 8'($urandom);
                stream.push_back(junk == 8'hA5 ? 8'h00 : junk);
            end
            for (int f = 0; f < 2; f++) begin
                ln  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 6));
                bad = ($urandom_range(0, 3) == 0);
                add_frame(ln, bad);
            end
            send_stream(r[0]);
            model();
            checks++;
            if ({done, err_checksum, err_length, cpu_hold} !== {exp_done, exp_errc, exp_errl, ~exp_done}) begin
                errors++;
                $display("FAIL rand%0d_flags: done/errc/errl/hold=%b required %b", r,
                         {done, err_checksum, err_length, cpu_hold}, {exp_done, exp_errc, exp_errl, ~exp_done});
            end
            checks++;
            if (obs.size() != exp_w.size()) begin
                errors++;
                $display("FAIL rand%0d_write_count: got %0d required %0d", r, obs.size(), exp_w.size());
            end else foreach (exp_w[k]) begin
                checks++;
                if (obs[k] !== exp_w[k]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got %h@%h rdy=%b b2b=%b required %h@%h rdy=0 b2b=0",
                             r, k, obs[k].data, obs[k].addr, obs[k].rdy, obs[k].b2b, exp_w[k].data, exp_w[k].addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_length_overflow();
        test_zero_length();
        test_handshake_gaps();
        test_reset_mid_word();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
